// File: rtl/ex_dispatch_pkg.sv
// Shared types for the execute-side dispatch block: ALU op encoding, branch
// types, RS/CDB packet structs and the EX-stage register layout.
package ex_dispatch_pkg;

  localparam int unsigned NUM_RS = 4;
  localparam int unsigned XLEN   = 32;
  localparam int unsigned ROB_W  = 5;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_AND  = 4'd2,
    ALU_OR   = 4'd3,
    ALU_XOR  = 4'd4,
    ALU_SLL  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_SLT  = 4'd8,
    ALU_SLTU = 4'd9
  } alu_op_e;

  localparam logic [1:0] BR_NONE = 2'd0;
  localparam logic [1:0] BR_BEQ  = 2'd1;
  localparam logic [1:0] BR_BNE  = 2'd2;
  localparam logic [1:0] BR_BLT  = 2'd3;

  typedef struct packed {
    alu_op_e          ALU_op;
    logic [ROB_W-1:0] ROB_entry;
    logic [1:0]       branch_type;
    logic [XLEN-1:0]  rs1;
    logic [XLEN-1:0]  rs2;
    logic             load;
    logic             valid_operands;
  } rs_out_t;

  typedef struct packed {
    logic [ROB_W-1:0] dest_ROB_entry;
    logic [XLEN-1:0]  result;
    logic             load_step1;
  } CDB_packet_t;

  typedef struct packed {
    alu_op_e          alu_op;
    logic [ROB_W-1:0] rob_entry;
    logic [1:0]       branch_type;
    logic [XLEN-1:0]  rs1;
    logic [XLEN-1:0]  rs2;
    logic             load;
  } ex_reg_t;

  function automatic ex_reg_t to_ex(input rs_out_t r);
    ex_reg_t e;
    e.alu_op      = r.ALU_op;
    e.rob_entry   = r.ROB_entry;
    e.branch_type = r.branch_type;
    e.rs1         = r.rs1;
    e.rs2         = r.rs2;
    e.load        = r.load;
    return e;
  endfunction

endpackage

// File: rtl/ex_dispatch_alu_core.sv
// Combinational ALU: loads compute an effective address, branches resolve
// their outcome with a zero result, everything else goes through the op table.
module alu_core
  import ex_dispatch_pkg::*;
(
  input  alu_op_e         alu_op,
  input  logic [1:0]      branch_type,
  input  logic            load,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  output logic [XLEN-1:0] result,
  output logic            branch_taken
);

  logic [4:0] shamt;

  always_comb begin
    shamt        = op_b[4:0];
    result       = '0;
    branch_taken = 1'b0;
    if (load) begin
      result = op_a + op_b;
    end else if (branch_type != BR_NONE) begin
      case (branch_type)
        BR_BEQ:  branch_taken = (op_a == op_b);
        BR_BNE:  branch_taken = (op_a != op_b);
        default: branch_taken = ($signed(op_a) < $signed(op_b));
      endcase
    end else begin
      case (alu_op)
        ALU_ADD:  result = op_a + op_b;
        ALU_SUB:  result = op_a - op_b;
        ALU_AND:  result = op_a & op_b;
        ALU_OR:   result = op_a | op_b;
        ALU_XOR:  result = op_a ^ op_b;
        ALU_SLL:  result = op_a << shamt;
        ALU_SRL:  result = op_a >> shamt;
        ALU_SRA:  result = XLEN'($signed(op_a) >>> shamt);
        ALU_SLT:  result = {{(XLEN-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
        ALU_SLTU: result = {{(XLEN-1){1'b0}}, (op_a < op_b)};
        default:  result = '0;
      endcase
    end
  end

endmodule

// File: rtl/ex_dispatch.sv
// Picks one ready reservation station per cycle, runs it through EX and holds
// the result in OUT until the CDB grants it. EX_DISPATCH_RR_EN selects
// round-robin arbitration; otherwise RS0 has fixed highest priority.
module ex_dispatch
  import ex_dispatch_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        mispredicted,
  input  rs_out_t     rs0_data,
  input  rs_out_t     rs1_data,
  input  rs_out_t     rs2_data,
  input  rs_out_t     rs3_data,
  output logic [3:0]  consumed_bus,
  output logic        cdb_req,
  input  logic        cdb_grant,
  output CDB_packet_t cdb_out,
  output logic        branch_taken
);

  logic        ex_valid_q, ex_valid_d;
  ex_reg_t     ex_q, ex_d;
  logic        out_valid_q, out_valid_d;
  CDB_packet_t out_q, out_d;
  logic        br_q, br_d;
`ifdef EX_DISPATCH_RR_EN
  logic [1:0]  rr_ptr_q, rr_ptr_d;
`endif

  logic [3:0]      ready;
  logic [1:0]      base, idx, gidx;
  logic            found, granted;
  logic            out_free, ex_ready, ex_move, sel_en;
  logic [XLEN-1:0] alu_result;
  logic            alu_br;

  assign out_free = ~out_valid_q | cdb_grant;
  assign ex_ready = ~ex_valid_q | out_free;
  assign ex_move  = ex_valid_q & out_free;
  // Holding selection off during flush/reset keeps the stations' data intact.
  assign sel_en   = ex_ready & ~mispredicted & ~reset;

  always_comb begin
    ready = {rs3_data.valid_operands, rs2_data.valid_operands,
             rs1_data.valid_operands, rs0_data.valid_operands};
`ifdef EX_DISPATCH_RR_EN
    base = rr_ptr_q;
`else
    base = '0;
`endif
    idx   = '0;
    gidx  = '0;
    found = 1'b0;
    for (int unsigned k = 0; k < NUM_RS; k++) begin
      idx = base + 2'(k);
      if (!found && ready[idx]) begin
        found = 1'b1;
        gidx  = idx;
      end
    end
    granted      = found & sel_en;
    consumed_bus = '0;
    if (granted) consumed_bus[gidx] = 1'b1;
  end

  alu_core u_alu (
    .alu_op       (ex_q.alu_op),
    .branch_type  (ex_q.branch_type),
    .load         (ex_q.load),
    .op_a         (ex_q.rs1),
    .op_b         (ex_q.rs2),
    .result       (alu_result),
    .branch_taken (alu_br)
  );

  always_comb begin
    ex_d = ex_q;
    if (granted) begin
      case (gidx)
        2'd0:    ex_d = to_ex(rs0_data);
        2'd1:    ex_d = to_ex(rs1_data);
        2'd2:    ex_d = to_ex(rs2_data);
        default: ex_d = to_ex(rs3_data);
      endcase
    end
    ex_valid_d  = ~mispredicted & (granted | (ex_valid_q & ~out_free));

    out_d = out_q;
    br_d  = br_q;
    if (ex_move) begin
      out_d.dest_ROB_entry = ex_q.rob_entry;
      out_d.result         = alu_result;
      out_d.load_step1     = ex_q.load;
      br_d                 = alu_br;
    end
    out_valid_d = ~mispredicted & (ex_move | (out_valid_q & ~cdb_grant));
`ifdef EX_DISPATCH_RR_EN
    rr_ptr_d = granted ? gidx + 2'd1 : rr_ptr_q;
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ex_valid_q  <= 1'b0;
      ex_q        <= '0;
      out_valid_q <= 1'b0;
      out_q       <= '0;
      br_q        <= 1'b0;
`ifdef EX_DISPATCH_RR_EN
      rr_ptr_q    <= '0;
`endif
    end else begin
      ex_valid_q  <= ex_valid_d;
      ex_q        <= ex_d;
      out_valid_q <= out_valid_d;
      out_q       <= out_d;
      br_q        <= br_d;
`ifdef EX_DISPATCH_RR_EN
      rr_ptr_q    <= rr_ptr_d;
`endif
    end
  end

  assign cdb_req      = out_valid_q;
  assign cdb_out      = out_q;
  assign branch_taken = br_q;

endmodule

// File: tb/tb_ex_dispatch.sv
// Bench for ex_dispatch: a two-slot in-flight queue model checked every cycle,
// plus directed scenarios with hand-computed literal expectations.
module tb_ex_dispatch;
  import ex_dispatch_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        mispredicted;
  logic        cdb_grant;
  rs_out_t     rs [4];
  logic [3:0]  consumed_bus;
  logic        cdb_req;
  CDB_packet_t cdb_out;
  logic        branch_taken;

  ex_dispatch dut (
    .clk          (clk),
    .reset        (reset),
    .mispredicted (mispredicted),
    .rs0_data     (rs[0]),
    .rs1_data     (rs[1]),
    .rs2_data     (rs[2]),
    .rs3_data     (rs[3]),
    .consumed_bus (consumed_bus),
    .cdb_req      (cdb_req),
    .cdb_grant    (cdb_grant),
    .cdb_out      (cdb_out),
    .branch_taken (branch_taken)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_pass  = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end else begin
      n_pass++;
    end
  endtask

  // What the spec says an op must produce, computed directly from its fields.
  function automatic void model_op(input rs_out_t r, output CDB_packet_t p, output logic br);
    p.dest_ROB_entry = r.ROB_entry;
    p.load_step1     = r.load;
    p.result         = '0;
    br               = 1'b0;
    if (r.load) p.result = r.rs1 + r.rs2;
    else if (r.branch_type == 2'd1) br = (r.rs1 == r.rs2);
    else if (r.branch_type == 2'd2) br = (r.rs1 != r.rs2);
    else if (r.branch_type == 2'd3) br = ($signed(r.rs1) < $signed(r.rs2));
    else begin
      case (r.ALU_op)
        ALU_ADD:  p.result = r.rs1 + r.rs2;
        ALU_SUB:  p.result = r.rs1 - r.rs2;
        ALU_AND:  p.result = r.rs1 & r.rs2;
        ALU_OR:   p.result = r.rs1 | r.rs2;
        ALU_XOR:  p.result = r.rs1 ^ r.rs2;
        ALU_SLL:  p.result = r.rs1 << r.rs2[4:0];
        ALU_SRL:  p.result = r.rs1 >> r.rs2[4:0];
        ALU_SRA:  p.result = $signed(r.rs1) >>> r.rs2[4:0];
        ALU_SLT:  p.result = ($signed(r.rs1) < $signed(r.rs2)) ? 32'd1 : 32'd0;
        ALU_SLTU: p.result = (r.rs1 < r.rs2) ? 32'd1 : 32'd0;
        default:  p.result = '0;
      endcase
    end
  endfunction

  typedef struct {
    CDB_packet_t pkt;
    logic        br;
    int          vis;
  } inflight_t;

  inflight_t  mq[$];
  int         cyc = 0;
  logic       chk_en = 1'b0;
  logic [3:0] cons_seen = '0;
`ifdef EX_DISPATCH_RR_EN
  int         mptr = 0;
`endif

  function automatic int pick();
    int base;
`ifdef EX_DISPATCH_RR_EN
    base = mptr;
`else
    base = 0;
`endif
    for (int k = 0; k < 4; k++)
      if (rs[(base + k) % 4].valid_operands) return (base + k) % 4;
    return -1;
  endfunction

  // Model: at most two ops in flight (one in OUT, one in EX); an op granted in
  // cycle N is visible from N+2; a CDB grant frees a slot in the same cycle.
  always @(negedge clk) begin
    logic       exp_req;
    logic [3:0] exp_cons;
    int         g;
    inflight_t  e;
    exp_req  = (mq.size() > 0) && (mq[0].vis <= cyc);
    exp_cons = '0;
    g        = -1;
    if (chk_en) begin
      chk("cdb_req", {63'd0, cdb_req}, {63'd0, exp_req});
      if (exp_req) begin
        chk("cdb_out", {26'd0, cdb_out}, {26'd0, mq[0].pkt});
        chk("branch_taken", {63'd0, branch_taken}, {63'd0, mq[0].br});
      end
      if (!reset && !mispredicted && (mq.size() < 2 || cdb_grant)) g = pick();
      if (g >= 0) exp_cons[g] = 1'b1;
      chk("consumed_bus", {60'd0, consumed_bus}, {60'd0, exp_cons});
      cons_seen = consumed_bus;
    end
    if (reset) begin
      mq.delete();
`ifdef EX_DISPATCH_RR_EN
      mptr = 0;
`endif
    end else if (mispredicted) begin
      mq.delete();
    end else begin
      if (cdb_grant && exp_req) void'(mq.pop_front());
      if (g >= 0) begin
        model_op(rs[g], e.pkt, e.br);
        e.vis = cyc + 2;
        mq.push_back(e);
`ifdef EX_DISPATCH_RR_EN
        mptr = (g + 1) % 4;
`endif
      end
    end
    cyc++;
  end

  logic refill = 1'b0;

  task automatic tick();
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++)
      if (cons_seen[i] && !refill) rs[i].valid_operands = 1'b0;
  endtask

  task automatic set_rs(input int i, input alu_op_e op, input logic [4:0] rob,
                        input logic [1:0] bt, input logic [31:0] a, input logic [31:0] b,
                        input logic ld);
    rs[i] = '{ALU_op: op, ROB_entry: rob, branch_type: bt, rs1: a, rs2: b,
              load: ld, valid_operands: 1'b1};
  endtask

  task automatic clear_rs();
    for (int i = 0; i < 4; i++) rs[i] = '0;
  endtask

  task automatic do_reset();
    clear_rs();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  alu_op_e     t_op [8] = '{ALU_AND, ALU_OR, ALU_SRL, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_ADD, ALU_SUB};
  logic [31:0] t_a  [8] = '{32'hF0F0_1234, 32'h0000_00F0, 32'h8000_0000, 32'h0000_0003,
                            32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000};
  logic [31:0] t_b  [8] = '{32'h0FF0_FFFF, 32'h0000_000F, 32'h0000_003F, 32'h0000_0021,
                            32'h0000_0001, 32'h0000_0001, 32'h0000_0001, 32'h0000_0001};
  logic [3:0]  seq  [5];
  int          guard;

  initial begin
`ifdef EX_DISPATCH_RR_EN
    seq = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
`else
    seq = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0001};
`endif
    clear_rs();
    reset = 1'b1; mispredicted = 1'b0; cdb_grant = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_en = 1'b1;
    reset  = 1'b0;

    // Reset state
    @(negedge clk);
    chk("rst_cdb_req", {63'd0, cdb_req}, 64'd0);
    chk("rst_cdb_out", {26'd0, cdb_out}, 64'd0);
    chk("rst_branch", {63'd0, branch_taken}, 64'd0);
    chk("rst_consumed", {60'd0, consumed_bus}, 64'd0);
    tick();

    // Single ADD: consumed in cycle 0, result visible in cycle 2
    cdb_grant = 1'b1;
    set_rs(0, ALU_ADD, 5'd3, 2'd0, 32'd5, 32'd7, 1'b0);
    @(negedge clk);
    chk("add_consumed", {60'd0, consumed_bus}, 64'b0001);
    tick();
    @(negedge clk);
    chk("add_c1_req", {63'd0, cdb_req}, 64'd0);
    tick();
    @(negedge clk);
    chk("add_c2_req", {63'd0, cdb_req}, 64'd1);
    chk("add_result", {32'd0, cdb_out.result}, 64'd12);
    chk("add_rob", {59'd0, cdb_out.dest_ROB_entry}, 64'd3);
    chk("add_ld1", {63'd0, cdb_out.load_step1}, 64'd0);
    repeat (2) tick();

    // Arbitration order with every station kept ready
    do_reset();
    cdb_grant = 1'b1;
    refill    = 1'b1;
    for (int i = 0; i < 4; i++) set_rs(i, ALU_ADD, 5'(i + 1), 2'd0, 32'(i), 32'd1, 1'b0);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("arb_seq", {60'd0, consumed_bus}, {60'd0, seq[k]});
      tick();
    end
    refill = 1'b0;
    clear_rs();
    repeat (3) tick();

    // Backpressure, then drain in order with no bubble
    do_reset();
    cdb_grant = 1'b0;
    set_rs(0, ALU_SUB, 5'd1, 2'd0, 32'd10, 32'd3, 1'b0);
    set_rs(1, ALU_XOR, 5'd2, 2'd0, 32'h0000_F0F0, 32'h0000_0FF0, 1'b0);
    set_rs(2, ALU_SRA, 5'd3, 2'd0, 32'h8000_0000, 32'h0000_0024, 1'b0);
    repeat (2) tick();
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("bp_consumed", {60'd0, consumed_bus}, 64'd0);
      chk("bp_hold", {32'd0, cdb_out.result}, 64'd7);
      tick();
    end
    cdb_grant = 1'b1;
    @(negedge clk);
    chk("drain0", {32'd0, cdb_out.result}, 64'd7);
    tick();
    @(negedge clk);
    chk("drain1", {32'd0, cdb_out.result}, 64'h0000_FF00);
    tick();
    @(negedge clk);
    chk("drain2", {32'd0, cdb_out.result}, 64'hF800_0000);
    chk("drain2_req", {63'd0, cdb_req}, 64'd1);
    tick();
    @(negedge clk);
    chk("drained_req", {63'd0, cdb_req}, 64'd0);
    tick();

    // Load effective address
    set_rs(3, ALU_ADD, 5'd7, 2'd0, 32'h0000_1000, 32'h0000_0010, 1'b1);
    repeat (2) tick();
    @(negedge clk);
    chk("ld_result", {32'd0, cdb_out.result}, 64'h1010);
    chk("ld_step1", {63'd0, cdb_out.load_step1}, 64'd1);
    chk("ld_branch", {63'd0, branch_taken}, 64'd0);
    tick();

    // Branches
    do_reset();
    set_rs(1, ALU_ADD, 5'd4, 2'd2, 32'd4, 32'd4, 1'b0);
    set_rs(2, ALU_ADD, 5'd5, 2'd3, 32'hFFFF_FFFF, 32'd1, 1'b0);
    repeat (2) tick();
    @(negedge clk);
    chk("bne_taken", {63'd0, branch_taken}, 64'd0);
    chk("bne_rob", {59'd0, cdb_out.dest_ROB_entry}, 64'd4);
    tick();
    @(negedge clk);
    chk("blt_taken", {63'd0, branch_taken}, 64'd1);
    chk("blt_result", {32'd0, cdb_out.result}, 64'd0);
    tick();

    // Op table with irregular grant
    for (int i = 0; i < 8; i++) begin
      set_rs(0, t_op[i], 5'(i + 8), 2'd0, t_a[i], t_b[i], 1'b0);
      cdb_grant = (i % 3 != 2);
      tick();
      guard = 0;
      while (rs[0].valid_operands && guard < 20) begin
        cdb_grant = 1'b1;
        tick();
        guard++;
      end
      if (guard >= 20) chk("optable_timeout", 64'd1, 64'd0);
    end
    cdb_grant = 1'b1;
    repeat (4) tick();

    // Flush with ops in EX and OUT and RS1 waiting
    do_reset();
    cdb_grant = 1'b0;
    set_rs(0, ALU_ADD, 5'd8, 2'd0, 32'd1, 32'd2, 1'b0);
    set_rs(2, ALU_OR, 5'd9, 2'd0, 32'd3, 32'd4, 1'b0);
    repeat (2) tick();
    set_rs(1, ALU_XOR, 5'd10, 2'd0, 32'd5, 32'd6, 1'b0);
    @(negedge clk);
    chk("fl_full_cons", {60'd0, consumed_bus}, 64'd0);
    chk("fl_full_req", {63'd0, cdb_req}, 64'd1);
    tick();
    mispredicted = 1'b1;
    cdb_grant    = 1'b1;
    @(negedge clk);
    chk("fl_cons", {60'd0, consumed_bus}, 64'd0);
    tick();
    mispredicted = 1'b0;
    @(negedge clk);
    chk("fl_req", {63'd0, cdb_req}, 64'd0);
    chk("fl_rs1_kept", {60'd0, consumed_bus}, 64'b0010);
    repeat (2) tick();
    @(negedge clk);
    chk("fl_after", {32'd0, cdb_out.result}, 64'd3);
    chk("fl_after_rob", {59'd0, cdb_out.dest_ROB_entry}, 64'd10);
    tick();

    // Reset mid-stream
    cdb_grant = 1'b0;
    set_rs(0, ALU_ADD, 5'd11, 2'd0, 32'd9, 32'd9, 1'b0);
    set_rs(3, ALU_SUB, 5'd12, 2'd0, 32'd9, 32'd1, 1'b0);
    repeat (3) tick();
    reset = 1'b1;
    @(negedge clk);
    chk("mrst_cons", {60'd0, consumed_bus}, 64'd0);
    tick();
    reset = 1'b0;
    @(negedge clk);
    chk("mrst_req", {63'd0, cdb_req}, 64'd0);
    chk("mrst_out", {26'd0, cdb_out}, 64'd0);
    chk("mrst_branch", {63'd0, branch_taken}, 64'd0);
    tick();
    tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/ex_dispatch.md
Name: ex_dispatch

Overview:
- Execute-side neighbour of the reservation-station bank. Each cycle it picks one RS whose operands are ready, pulses that station's consumed bit, and runs the op through a two-stage ALU pipeline.
- The result is held in an output register until the CDB arbiter grants it.
- The RS bank sits upstream; the CDB arbiter sits downstream and broadcasts results back to the RS bank and the ROB.

Parameters:
NUM_RS, 4, number of reservation stations scanned (fixed at 4 by the 4-bit consumed_bus).
XLEN, 32, operand/result width.

Ports:
clk  in  1  system clock.
reset  in  1  synchronous, active-high reset.
mispredicted  in  1  pipeline flush.
rs0_data..rs3_data  in  rs_out_t  per-station ALU_op, ROB_entry, branch_type, rs1, rs2, load, valid_operands.
consumed_bus  out  4  one-hot; bit i consumes RS i; combinational.
cdb_req  out  1  output register holds a valid result.
cdb_grant  in  1  CDB arbiter accepts cdb_out this cycle.
cdb_out  out  CDB_packet_t  dest_ROB_entry, result, load_step1.
branch_taken  out  1  branch outcome for the op in cdb_out; 0 for non-branches.

Behaviour:
- Stages:
  - SEL (comb) -> EX register -> OUT register.
  - Latency: selected in cycle N; EX valid in N+1; cdb_req high from N+2.
- Ready set: ready[i] = rsi_data.valid_operands.
- Selection:
  - Round-robin starting at rr_ptr.
  - Grant g sets consumed_bus[g] = 1 and captures the station's fields into EX at the next edge.
  - On grant, rr_ptr <= g+1 mod 4. rr_ptr is unchanged when nothing is granted.
- Advance rule:
  - out_free = ~out_valid | cdb_grant.
  - EX moves to OUT when ex_valid & out_free.
  - ex_ready = ~ex_valid | out_free.
  - Selection is allowed only when ex_ready. Otherwise consumed_bus = 0 and the stations keep their data.
- EX compute (registered into OUT):
  - ALU_op encodes ADD, SUB, AND, OR, XOR, SLL, SRL, SRA, SLT, SLTU.
  - Shifts use rs2[4:0]. SLT/SLTU produce a 0/1 result. Arithmetic wraps modulo 2^XLEN.
  - load=1: result = rs1+rs2 (effective address) and load_step1 = 1.
  - branch_type != 0: result = 0; branch_taken per type (1 = BEQ, 2 = BNE, 3 = BLT signed).
  - dest_ROB_entry = ROB_entry.
- OUT holds its value while cdb_req & ~cdb_grant. cdb_out stays stable until granted.
- Simultaneous events:
  - cdb_grant with ex_valid: OUT reloads the same edge (no bubble).
  - cdb_grant with ~ex_valid: cdb_req drops.
- mispredicted:
  - ex_valid and out_valid clear at the next edge; consumed_bus is forced to 0 that cycle.
  - rr_ptr is preserved.
  - mispredicted overrides cdb_grant.
- Reset:
  - ex_valid = out_valid = 0, rr_ptr = 0.
  - cdb_out all-zero, branch_taken = 0, cdb_req = 0, consumed_bus = 0.
  - Reset applied mid-operation drops any in-flight op.
- consumed_bus never has more than one bit set.

Optional Feature:
- Macro: EX_DISPATCH_RR_EN.
- Defined: round-robin selection as above.
- Undefined: fixed priority, RS0 highest and RS3 lowest. rr_ptr is removed; all other timing is identical.

Decomposition:
- Shared package (structs.svh):
  - ALU_op encoding enum.
  - branch_type constants (NONE = 0, BEQ = 1, BNE = 2, BLT = 3).
  - ex_reg_t for the EX register contents.
  - rs_out_t and CDB_packet_t reused unchanged.
- One sub-module, alu_core: combinational op/operand -> result/branch_taken. It is instantiated in the EX stage.

Test Plan:
- Single ADD: RS0 ready with rs1=5, rs2=7, ROB_entry=3 in cycle 0 -> consumed_bus=0001 in cycle 0; in cycle 2, cdb_req=1, result=12, dest_ROB_entry=3, load_step1=0.
- Round-robin: all four stations ready, grant tied high -> consumed_bus sequence 0001, 0010, 0100, 1000, 0001. With EX_DISPATCH_RR_EN undefined and RS0 refilled every cycle, the sequence is 0001 every cycle.
- Backpressure: cdb_grant=0 for 5 cycles with 3 ops ready -> one op in OUT and one in EX, consumed_bus=0, cdb_out stable. On grant, the results drain in order with no bubble between them.
- Load: load=1, rs1=0x1000, rs2=0x10 -> result=0x1010, load_step1=1.
- Branch: BNE with rs1=4, rs2=4 -> branch_taken=0; BLT with rs1=0xFFFFFFFF, rs2=1 -> branch_taken=1.
- Flush: mispredicted asserted with ops in EX and OUT and RS1 ready -> next cycle cdb_req=0, consumed_bus=0 during the flush cycle. Reset asserted mid-stream likewise gives all outputs zero after the edge.
